// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared line-state constants, state enum and defaults for the USB receive controller
package usb_rx_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam int CLKS_PER_BIT_DEF = 8;

    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RX,
        ST_EOP,
        ST_ERR
    } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - bit-period counter with edge resync and mid-bit sample strobe
module rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic line_edge,
    output logic sample
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!run || line_edge || count_q == CNT_LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // An edge on the would-be sample cycle resynchronises instead of sampling.
    assign sample = run && !line_edge && (count_q == CNT_MID);

endmodule

// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - full-speed USB receive line controller: SYNC/EOP tracking, NRZI decode, bit de-stuffing
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] USB_sync,
    output logic       rx_bit,
    output logic       bit_valid,
    output logic       receiving,
    output logic       eop,
    output logic       rx_error
);

    rx_state_e  state_q, state_d;
    logic [1:0] last_q;
    logic [1:0] prev_q, prev_d;
    logic [2:0] seq_q, seq_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       rx_bit_q, rx_bit_d;
    logic       bit_valid_q, bit_valid_d;
    logic       eop_q, eop_d;
    logic       rx_error_q, rx_error_d;
    logic       receiving_q, receiving_d;

    logic sample;
    logic line_edge;
    logic dec_bit;
    logic to_err;

    assign line_edge = (USB_sync != last_q);
    assign dec_bit   = (USB_sync == prev_q);

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q != ST_IDLE),
        .line_edge(line_edge),
        .sample   (sample)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        seq_d       = seq_q;
        ones_d      = ones_q;
        bitcnt_d    = bitcnt_q;
        rx_bit_d    = 1'b0;
        bit_valid_d = 1'b0;
        eop_d       = 1'b0;
        rx_error_d  = 1'b0;
        receiving_d = receiving_q;
        to_err      = 1'b0;

        if (sample) begin
            prev_d = USB_sync;
        end

        case (state_q)
            ST_IDLE: begin
                if (USB_sync == LINE_K) begin
                    state_d  = ST_SYNC;
                    prev_d   = LINE_J;
                    seq_d    = 3'd0;
                    ones_d   = 3'd0;
                    bitcnt_d = 3'd0;
                end
            end
            ST_SYNC: begin
                if (sample) begin
                    if (USB_sync == LINE_SE0 || USB_sync == LINE_SE1) begin
                        to_err = 1'b1;
                    end else if (seq_q != 3'd7) begin
                        if (dec_bit) to_err = 1'b1;
                        else         seq_d  = seq_q + 3'd1;
                    end else if (dec_bit) begin
                        state_d     = ST_RX;
                        receiving_d = 1'b1;
                    end else begin
                        to_err = 1'b1;
                    end
                end
            end
            ST_RX: begin
                if (sample) begin
                    if (USB_sync == LINE_SE1) begin
                        to_err = 1'b1;
                    end else if (USB_sync == LINE_SE0) begin
                        state_d = ST_EOP;
                        seq_d   = 3'd0;
                    end else if (ones_q == STUFF_LIMIT) begin
                        // Six ones in a row: this slot must be a stuffed zero.
                        if (dec_bit) to_err = 1'b1;
                        else         ones_d = 3'd0;
                    end else begin
                        rx_bit_d    = dec_bit;
                        bit_valid_d = 1'b1;
                        bitcnt_d    = bitcnt_q + 3'd1;
                        ones_d      = dec_bit ? ones_q + 3'd1 : 3'd0;
                    end
                end
            end
            ST_EOP: begin
                if (sample) begin
                    if (seq_q == 3'd0) begin
                        if (USB_sync == LINE_SE0) seq_d  = 3'd1;
                        else                      to_err = 1'b1;
                    end else if (USB_sync == LINE_J && bitcnt_q == 3'd0) begin
                        eop_d       = 1'b1;
                        receiving_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        to_err = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                if (sample) begin
                    if (USB_sync != LINE_J) begin
                        seq_d = 3'd0;
                    end else if (seq_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end else begin
                        seq_d = seq_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_err) begin
            state_d     = ST_ERR;
            seq_d       = 3'd0;
            rx_error_d  = 1'b1;
            receiving_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_q      <= LINE_J;
            prev_q      <= LINE_J;
            seq_q       <= 3'd0;
            ones_q      <= 3'd0;
            bitcnt_q    <= 3'd0;
            rx_bit_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            eop_q       <= 1'b0;
            rx_error_q  <= 1'b0;
            receiving_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= USB_sync;
            prev_q      <= prev_d;
            seq_q       <= seq_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            rx_bit_q    <= rx_bit_d;
            bit_valid_q <= bit_valid_d;
            eop_q       <= eop_d;
            rx_error_q  <= rx_error_d;
            receiving_q <= receiving_d;
        end
    end

    assign rx_bit    = rx_bit_q;
    assign bit_valid = bit_valid_q;
    assign eop       = eop_q;
    assign rx_error  = rx_error_q;
    assign receiving = receiving_q;

endmodule
